// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner of a shared 16-to-1 mux: picks one requester, drives the mux select
// and a one-hot grant, and holds ownership until done, withdrawal or the hold limit.
module mux16_rr_scheduler #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:15] req,
    input  logic        done,
    output logic [0:3]  sel,
    output logic [0:15] grant,
    output logic        valid
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      r_state;
    logic [3:0]  r_sel;
    logic [3:0]  r_ptr;
    logic [3:0]  r_hold;
    logic [0:15] r_grant;
    logic        r_valid;

    logic [3:0]  w_start;
    logic [3:0]  w_win;
    logic        w_found;
    logic        w_release;
    logic [0:15] w_dec;

    // On a release the search starts at sel+1, so the releasing index is visited last:
    // it can only win when nobody else is requesting, which is exactly the exclusion rule.
    always_comb begin
        logic [3:0] idx;
        w_start = (r_state == S_BUSY) ? r_sel + 4'd1 : r_ptr;
        w_found = 1'b0;
        w_win   = 4'd0;
        idx     = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            idx = w_start + 4'(k);
            if (req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_release = done || !req[r_sel] || (r_hold == 4'(MAX_HOLD - 1));

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dec
            assign w_dec[gi] = (w_win == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 4'd0;
            r_ptr   <= 4'd0;
            r_hold  <= 4'd0;
            r_grant <= 16'd0;
            r_valid <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_state <= S_BUSY;
                r_sel   <= w_win;
                r_grant <= w_dec;
                r_valid <= 1'b1;
                r_hold  <= 4'd0;
            end
        end else begin
            if (w_release) begin
                r_ptr  <= r_sel + 4'd1;
                r_hold <= 4'd0;
                if (w_found) begin
                    r_sel   <= w_win;
                    r_grant <= w_dec;
                end else begin
                    r_state <= S_IDLE;
                    r_grant <= 16'd0;
                    r_valid <= 1'b0;
                end
            end else begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

    assign sel   = r_sel;
    assign grant = r_grant;
    assign valid = r_valid;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Bench for mux16_rr_scheduler: directed scenarios plus random traffic on two instances
// (hold limits 4 and 1), each checked against a set-based round-robin reference model.
module tb_mux16_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:15] req;
    logic        done;
    logic [0:3]  sel0, sel1;
    logic [0:15] grant0, grant1;
    logic        valid0, valid1;

    int n_checks = 0;
    int n_errors = 0;

    int mh[2];
    int m_valid[2];
    int m_sel[2];
    int m_ptr[2];
    int m_hold[2];
    int seq2[4];
    int seq2b[3];

    always #5 clk = ~clk;

    mux16_rr_scheduler #(.MAX_HOLD(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .done  (done),
        .sel   (sel0),
        .grant (grant0),
        .valid (valid0)
    );

    mux16_rr_scheduler #(.MAX_HOLD(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .done  (done),
        .sel   (sel1),
        .grant (grant1),
        .valid (valid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requester at or after start (mod 16), skipping excl unless it is the only one.
    function automatic int arb(input logic [0:15] r, input int start, input int excl);
        for (int k = 0; k < 16; k++) begin
            int i;
            i = (start + k) % 16;
            if (r[i] && i != excl) return i;
        end
        if (excl >= 0 && r[excl]) return excl;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            m_sel[d]   = 0;
            m_ptr[d]   = 0;
            m_hold[d]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int w;
            if (!rst_n) begin
                m_valid[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_hold[d] = 0;
            end else if (m_valid[d] == 0) begin
                w = arb(req, m_ptr[d], -1);
                if (w >= 0) begin
                    m_valid[d] = 1; m_sel[d] = w; m_hold[d] = 0;
                end
            end else if (done || !req[m_sel[d]] || m_hold[d] == mh[d] - 1) begin
                m_ptr[d]  = (m_sel[d] + 1) % 16;
                m_hold[d] = 0;
                w = arb(req, m_ptr[d], m_sel[d]);
                if (w >= 0) m_sel[d] = w;
                else        m_valid[d] = 0;
            end else begin
                m_hold[d]++;
            end
        end
    endtask

    task automatic compare_all();
        logic [0:15] g0, g1;
        g0 = (m_valid[0] != 0) ? (16'h8000 >> m_sel[0]) : 16'h0000;
        g1 = (m_valid[1] != 0) ? (16'h8000 >> m_sel[1]) : 16'h0000;
        chk("d0_sel",   32'(sel0),   m_sel[0]);
        chk("d0_grant", 32'(grant0), 32'(g0));
        chk("d0_valid", 32'(valid0), m_valid[0]);
        chk("d1_sel",   32'(sel1),   m_sel[1]);
        chk("d1_grant", 32'(grant1), 32'(g1));
        chk("d1_valid", 32'(valid1), m_valid[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        $display("t=%0t rst_n=%b req=%h done=%b | d0 sel=%0d v=%b g=%h | d1 sel=%0d v=%b g=%h",
                 $time, rst_n, req, done, sel0, valid0, grant0, sel1, valid1, grant1);
    endtask

    initial begin
        mh[0] = 4; mh[1] = 1;
        seq2[0] = 3; seq2[1] = 7; seq2[2] = 12; seq2[3] = 3;
        seq2b[0] = 3; seq2b[1] = 7; seq2b[2] = 12;

        // Reset with every line requesting
        rst_n = 1'b0; req = 16'hFFFF; done = 1'b0;
        model_reset();
        #3;
        compare_all();
        chk("rst_sel", 32'(sel0), 0);
        chk("rst_grant", 32'(grant0), 0);
        chk("rst_valid", 32'(valid0), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t1_sel", 32'(sel0), 0);
        chk("t1_grant", 32'(grant0), 32'h8000);
        chk("t1_valid", 32'(valid0), 1);

        // Rotation among 3, 7, 12
        req = 16'h0000; req[3] = 1'b1; req[7] = 1'b1; req[12] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("t2_sel_h4", 32'(sel0), seq2[k / 4]);
            chk("t2_valid_h4", 32'(valid0), 1);
            chk("t2_sel_h1", 32'(sel1), seq2b[k % 3]);
        end

        // Early release by done, then pointer continues from 10
        req = 16'h0000; req[5] = 1'b1;
        step();
        chk("t3_sel5", 32'(sel0), 5);
        step();
        done = 1'b1; req[9] = 1'b1;
        step();
        chk("t3_sel9", 32'(sel0), 9);
        done = 1'b0; req = 16'h0000;
        step();
        chk("t3_idle", 32'(valid0), 0);
        req[5] = 1'b1; req[11] = 1'b1;
        step();
        chk("t3_ptr10", 32'(sel0), 11);

        // Wrap-around from 15 to 0, then all requests dropped
        req = 16'h0000; req[14] = 1'b1;
        step();
        step();
        chk("t4_sel14", 32'(sel0), 14);
        req = 16'h0000; req[0] = 1'b1; req[15] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_sel15", 32'(sel0), 15);
        end
        step();
        chk("t4_sel0", 32'(sel0), 0);
        req = 16'h0000;
        step();
        chk("t4_valid", 32'(valid0), 0);
        chk("t4_grant", 32'(grant0), 0);
        chk("t4_selkeep", 32'(sel0), 0);

        // Withdrawal and done while idle
        req[6] = 1'b1;
        step();
        chk("t5_sel6", 32'(sel0), 6);
        step();
        req = 16'h0000;
        step();
        chk("t5_idle", 32'(valid0), 0);
        done = 1'b1;
        step();
        chk("t5_done_idle_v", 32'(valid0), 0);
        chk("t5_done_idle_s", 32'(sel0), 6);
        done = 1'b0;

        // Asynchronous reset while sel=10
        req[10] = 1'b1;
        step();
        chk("t6_sel10", 32'(sel0), 10);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t6_async_valid", 32'(valid0), 0);
        chk("t6_async_grant", 32'(grant0), 0);
        chk("t6_async_sel", 32'(sel0), 0);
        req[2] = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_ptr0", 32'(sel0), 2);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 15) == 0)
                req = 16'h0000;
            done  = ($urandom_range(0, 5) == 0);
            rst_n = (n % 100 != 50);
            if (!rst_n) model_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
